// File: rtl/spi_xfer_sequencer.sv
// Byte sequencer in front of a full-duplex SPI core: TX FIFO feeds one transfer per byte, RX FIFO catches replies.
// Optional macro SPI_TIMEOUT_EN: abandon a transfer whose done never arrives and raise sticky timeout_err.
module spi_xfer_sequencer #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [DATA_W-1:0]      rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   spi_start,
  output logic [DATA_W-1:0]      spi_tx_data,
  input  logic [DATA_W-1:0]      spi_rx_data,
  input  logic                   spi_done,
  input  logic                   spi_busy,
  output logic [$clog2(DEPTH):0] tx_level,
  output logic [$clog2(DEPTH):0] rx_level,
  output logic                   idle,
  output logic                   timeout_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("spi_xfer_sequencer: DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_chk
    $error("spi_xfer_sequencer: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [AW-1:0]     tx_wr, tx_rd, rx_wr, rx_rd;
  logic              tx_push, tx_pop, rx_push, rx_pop;
  logic              spi_done_q, done_rise, launch_ok, timeout_hit;

  assign tx_ready  = (tx_level != LW'(DEPTH));
  assign rx_valid  = (rx_level != '0);
  assign rx_data   = rx_valid ? rx_mem[rx_rd] : '0;
  assign idle      = (state_q == S_IDLE) && (tx_level == '0);
  assign tx_push   = tx_valid && tx_ready;
  assign rx_pop    = rx_valid && rx_ready;
  assign done_rise = spi_done && !spi_done_q;
  // A free RX slot at launch guarantees the capture always fits.
  assign launch_ok = (tx_level != '0) && (rx_level != LW'(DEPTH)) && !spi_busy && !spi_done;

  always_ff @(posedge clk) begin : state_reg
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (launch_ok) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (done_rise || timeout_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : fsm_outputs
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    case (state_q)
      S_IDLE:  tx_pop  = launch_ok;
      S_WAIT:  rx_push = done_rise;
      default: ;
    endcase
  end

  // spi_tx_data is only reloaded by a launch pop, so it is stable for the whole transfer.
  always_ff @(posedge clk) begin : xfer_regs
    if (reset) begin
      spi_done_q  <= 1'b0;
      spi_start   <= 1'b0;
      spi_tx_data <= '0;
    end else begin
      spi_done_q <= spi_done;
      spi_start  <= (state_d == S_START);
      if (tx_pop) spi_tx_data <= tx_mem[tx_rd];
    end
  end

  always_ff @(posedge clk) begin : tx_ram
    if (tx_push) tx_mem[tx_wr] <= tx_data;
  end

  always_ff @(posedge clk) begin : tx_ctrl
    if (reset) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_level <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + AW'(1);
      tx_level <= tx_level + LW'(tx_push) - LW'(tx_pop);
    end
  end

  always_ff @(posedge clk) begin : rx_ram
    if (rx_push) rx_mem[rx_wr] <= spi_rx_data;
  end

  always_ff @(posedge clk) begin : rx_ctrl
    if (reset) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_level <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + AW'(1);
      rx_level <= rx_level + LW'(rx_push) - LW'(rx_pop);
    end
  end

`ifdef SPI_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] to_cnt;

  // Counts WAIT cycles; the last one without a done edge abandons the transfer.
  assign timeout_hit = (state_q == S_WAIT) && !done_rise &&
                       (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin : timeout_ctr
    if (reset) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_q == S_START)     to_cnt <= '0;
      else if (state_q == S_WAIT) to_cnt <= to_cnt + CW'(1);
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer with a behavioural SPI core (echo ~data or fixed 8'h3C).
// Build with SPI_TIMEOUT_EN defined to exercise the timeout path (TIMEOUT_CYCLES=16).
`timescale 1ns/1ps
module tb_spi_xfer_sequencer;

  localparam int unsigned DW = 8;
  localparam int unsigned LW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          spi_start;
  logic [DW-1:0] spi_tx_data;
  logic [DW-1:0] spi_rx_data;
  logic          spi_done;
  logic          spi_busy;
  logic [LW-1:0] tx_level;
  logic [LW-1:0] rx_level;
  logic          idle;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;

  // Core model state
  bit            echo = 1'b0;
  bit            mute = 1'b0;
  logic [DW-1:0] core_lat;
  int            core_cnt;
  logic          prev_start;
  int            n_starts = 0;
  int            n_viol   = 0;

  always #5 clk = ~clk;

  spi_xfer_sequencer #(.DATA_W(8), .DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .spi_start(spi_start), .spi_tx_data(spi_tx_data), .spi_rx_data(spi_rx_data),
    .spi_done(spi_done), .spi_busy(spi_busy),
    .tx_level(tx_level), .rx_level(rx_level), .idle(idle), .timeout_err(timeout_err)
  );

  // Behavioural core: busy for 4 cycles after start, then a one-cycle done with busy low.
  always @(posedge clk) begin
    if (reset) begin
      spi_busy    <= 1'b0;
      spi_done    <= 1'b0;
      spi_rx_data <= '0;
      core_cnt    <= 0;
      prev_start  <= 1'b0;
    end else begin
      spi_done   <= 1'b0;
      prev_start <= spi_start;
      if (spi_start) begin
        n_starts <= n_starts + 1;
        if (spi_busy || spi_done || prev_start) n_viol <= n_viol + 1;
        core_lat <= spi_tx_data;
        spi_busy <= 1'b1;
        core_cnt <= 3;
      end else if (spi_busy) begin
        if (spi_tx_data !== core_lat) n_viol <= n_viol + 1;
        if (core_cnt == 0) begin
          spi_busy <= 1'b0;
          if (!mute) begin
            spi_done    <= 1'b1;
            spi_rx_data <= echo ? ~core_lat : 8'h3C;
          end
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [DW-1:0] b);
    int n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 200) begin tick(); n++; end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL push_wait: tx_ready=%b want 1", tx_ready); end
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    tick(); tick();
    total++; if (tx_ready !== 1'b1)    begin bad++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready); end
    total++; if (rx_valid !== 1'b0)    begin bad++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
    total++; if (rx_data !== 8'h00)    begin bad++; $display("FAIL rst_rx_data: got %h want 00", rx_data); end
    total++; if (spi_start !== 1'b0)   begin bad++; $display("FAIL rst_spi_start: got %b want 0", spi_start); end
    total++; if (spi_tx_data !== 8'h00) begin bad++; $display("FAIL rst_spi_tx_data: got %h want 00", spi_tx_data); end
    total++; if (tx_level !== 3'd0)    begin bad++; $display("FAIL rst_tx_level: got %0d want 0", tx_level); end
    total++; if (rx_level !== 3'd0)    begin bad++; $display("FAIL rst_rx_level: got %0d want 0", rx_level); end
    total++; if (idle !== 1'b1)        begin bad++; $display("FAIL rst_idle: got %b want 1", idle); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int n = 0;
    int s0 = n_starts;
    int v0 = n_viol;
    bit hold_bad = 1'b0;
    echo = 1'b0; mute = 1'b0;
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    total++; if (spi_start !== 1'b0) begin bad++; $display("FAIL single_start_early: got %b want 0", spi_start); end
    total++; if (tx_level !== 3'd1)  begin bad++; $display("FAIL single_tx_level: got %0d want 1", tx_level); end
    tick();
    total++; if (spi_start !== 1'b1)      begin bad++; $display("FAIL single_start: got %b want 1", spi_start); end
    total++; if (spi_tx_data !== 8'hA5)   begin bad++; $display("FAIL single_spi_tx_data: got %h want a5", spi_tx_data); end
    total++; if (tx_level !== 3'd0)       begin bad++; $display("FAIL single_tx_pop: got %0d want 0", tx_level); end
    tick();
    total++; if (spi_start !== 1'b0) begin bad++; $display("FAIL single_start_width: got %b want 0", spi_start); end
    while (!rx_valid && n < 50) begin
      if (spi_tx_data !== 8'hA5) hold_bad = 1'b1;
      tick(); n++;
    end
    total++; if (rx_valid !== 1'b1)   begin bad++; $display("FAIL single_rx_wait: rx_valid=%b want 1", rx_valid); end
    total++; if (hold_bad !== 1'b0)   begin bad++; $display("FAIL single_tx_hold: changed=%b want 0", hold_bad); end
    total++; if (rx_data !== 8'h3C)   begin bad++; $display("FAIL single_rx_data: got %h want 3c", rx_data); end
    total++; if (rx_level !== 3'd1)   begin bad++; $display("FAIL single_rx_level: got %0d want 1", rx_level); end
    total++; if (idle !== 1'b1)       begin bad++; $display("FAIL single_idle: got %b want 1", idle); end
    total++; if (n_starts - s0 != 1)  begin bad++; $display("FAIL single_starts: got %0d want 1", n_starts - s0); end
    total++; if (n_viol != v0)        begin bad++; $display("FAIL single_protocol: got %0d want 0", n_viol - v0); end
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    total++; if (rx_level !== 3'd0) begin bad++; $display("FAIL single_pop: got %0d want 0", rx_level); end
  endtask

  task automatic test_burst();
    logic [DW-1:0] exp_q [4] = '{8'h5A, 8'hAA, 8'hF0, 8'h0F};
    int n = 0;
    int s0 = n_starts;
    int v0 = n_viol;
    echo = 1'b1;
    push_byte(8'hA5); push_byte(8'h55); push_byte(8'h0F); push_byte(8'hF0);
    while (rx_level != 3'd4 && n < 300) begin tick(); n++; end
    total++; if (rx_level !== 3'd4) begin bad++; $display("FAIL burst_rx_wait: got %0d want 4", rx_level); end
    for (int i = 0; i < 5; i++) tick();
    total++; if (n_starts - s0 != 4) begin bad++; $display("FAIL burst_starts: got %0d want 4", n_starts - s0); end
    total++; if (n_viol != v0)       begin bad++; $display("FAIL burst_protocol: got %0d want 0", n_viol - v0); end
    for (int i = 0; i < 4; i++) begin
      total++; if (rx_data !== exp_q[i]) begin bad++; $display("FAIL burst_rx_%0d: got %h want %h", i, rx_data, exp_q[i]); end
      rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    end
    total++; if (rx_level !== 3'd0) begin bad++; $display("FAIL burst_drain: got %0d want 0", rx_level); end
    total++; if (idle !== 1'b1)     begin bad++; $display("FAIL burst_idle: got %b want 1", idle); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int s0 = n_starts;
    echo = 1'b1; rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push_byte(DW'(i));
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL bp_tx_full_ready: got %b want 0", tx_ready); end
    total++; if (tx_level !== 3'd4) begin bad++; $display("FAIL bp_tx_full_level: got %0d want 4", tx_level); end
    push_byte(8'h06);
    while (rx_level != 3'd4 && n < 300) begin tick(); n++; end
    for (int i = 0; i < 20; i++) tick();
    total++; if (rx_level !== 3'd4)  begin bad++; $display("FAIL bp_rx_full: got %0d want 4", rx_level); end
    total++; if (n_starts - s0 != 4) begin bad++; $display("FAIL bp_starts: got %0d want 4", n_starts - s0); end
    total++; if (tx_level !== 3'd2)  begin bad++; $display("FAIL bp_tx_left: got %0d want 2", tx_level); end
    push_byte(8'h07); push_byte(8'h08);
    total++; if (tx_ready !== 1'b0)  begin bad++; $display("FAIL bp_tx_ready_drop: got %b want 0", tx_ready); end
    total++; if (rx_data !== 8'hFE)  begin bad++; $display("FAIL bp_rx_head: got %h want fe", rx_data); end
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    n = 0;
    while (!spi_start && n < 50) begin tick(); n++; end
    total++; if (spi_start !== 1'b1)    begin bad++; $display("FAIL bp_fifth_start: got %b want 1", spi_start); end
    total++; if (spi_tx_data !== 8'h05) begin bad++; $display("FAIL bp_fifth_data: got %h want 05", spi_tx_data); end
    n = 0;
    while (rx_level != 3'd4 && n < 50) begin tick(); n++; end
    total++; if (rx_level !== 3'd4) begin bad++; $display("FAIL bp_fifth_capture: got %0d want 4", rx_level); end
    total++; if (tx_level !== 3'd3) begin bad++; $display("FAIL bp_tx_after5: got %0d want 3", tx_level); end
    push_byte(8'h09);
    total++; if (tx_level !== 3'd4) begin bad++; $display("FAIL bp_refill: got %0d want 4", tx_level); end
  endtask

  task automatic test_full_both();
    logic [DW-1:0] exp_q [8] = '{8'hFC, 8'hFB, 8'hFA, 8'hF9, 8'hF8, 8'hF7, 8'hF6, 8'hF5};
    int k = 0;
    int n = 0;
    bit extra = 1'b0;
    total++; if (rx_data !== 8'hFD) begin bad++; $display("FAIL full_head: got %h want fd", rx_data); end
    rx_ready = 1'b1; tx_valid = 1'b1; tx_data = 8'h0A;
    tick();
    rx_ready = 1'b0;
    total++; if (rx_level !== 3'd3) begin bad++; $display("FAIL full_rx_dec: got %0d want 3", rx_level); end
    total++; if (tx_level !== 3'd4) begin bad++; $display("FAIL full_tx_hold: got %0d want 4", tx_level); end
    tick();
    total++; if (spi_start !== 1'b1)    begin bad++; $display("FAIL full_launch: got %b want 1", spi_start); end
    total++; if (spi_tx_data !== 8'h06) begin bad++; $display("FAIL full_launch_data: got %h want 06", spi_tx_data); end
    total++; if (tx_level !== 3'd3)     begin bad++; $display("FAIL full_tx_pop: got %0d want 3", tx_level); end
    tick();
    tx_valid = 1'b0;
    total++; if (tx_level !== 3'd4) begin bad++; $display("FAIL full_tx_accept: got %0d want 4", tx_level); end
    rx_ready = 1'b1;
    while (k < 8 && n < 400) begin
      if (rx_valid) begin
        total++; if (rx_data !== exp_q[k]) begin bad++; $display("FAIL full_drain_%0d: got %h want %h", k, rx_data, exp_q[k]); end
        k++;
      end
      tick(); n++;
    end
    total++; if (k != 8) begin bad++; $display("FAIL full_drain_count: got %0d want 8", k); end
    for (int i = 0; i < 20; i++) begin
      if (rx_valid) extra = 1'b1;
      tick();
    end
    rx_ready = 1'b0;
    total++; if (extra !== 1'b0) begin bad++; $display("FAIL full_duplicate: extra=%b want 0", extra); end
    total++; if (idle !== 1'b1)  begin bad++; $display("FAIL full_idle: got %b want 1", idle); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit stray = 1'b0;
    echo = 1'b1; mute = 1'b0;
    push_byte(8'h33);
    while (!spi_busy && n < 20) begin tick(); n++; end
    total++; if (spi_busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_wait: got %b want 1", spi_busy); end
    reset = 1'b1;
    tick();
    total++; if (tx_ready !== 1'b1)     begin bad++; $display("FAIL rmid_tx_ready: got %b want 1", tx_ready); end
    total++; if (rx_valid !== 1'b0)     begin bad++; $display("FAIL rmid_rx_valid: got %b want 0", rx_valid); end
    total++; if (spi_start !== 1'b0)    begin bad++; $display("FAIL rmid_spi_start: got %b want 0", spi_start); end
    total++; if (spi_tx_data !== 8'h00) begin bad++; $display("FAIL rmid_spi_tx_data: got %h want 00", spi_tx_data); end
    total++; if (idle !== 1'b1)         begin bad++; $display("FAIL rmid_idle: got %b want 1", idle); end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (spi_start) stray = 1'b1;
      tick();
    end
    total++; if (stray !== 1'b0)    begin bad++; $display("FAIL rmid_stray_start: got %b want 0", stray); end
    total++; if (rx_level !== 3'd0) begin bad++; $display("FAIL rmid_rx_level: got %0d want 0", rx_level); end
    push_byte(8'h55);
    n = 0;
    while (!rx_valid && n < 50) begin tick(); n++; end
    total++; if (rx_data !== 8'hAA)  begin bad++; $display("FAIL rmid_capture: got %h want aa", rx_data); end
    total++; if (rx_level !== 3'd1)  begin bad++; $display("FAIL rmid_rx_one: got %0d want 1", rx_level); end
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
  endtask

  task automatic test_no_done();
    int n = 0;
    echo = 1'b1; mute = 1'b1;
    push_byte(8'h77);
    while (!spi_start && n < 20) begin tick(); n++; end
    total++; if (spi_start !== 1'b1) begin bad++; $display("FAIL nodone_start: got %b want 1", spi_start); end
`ifdef SPI_TIMEOUT_EN
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_err_early: got %b want 0", timeout_err); end
    for (int i = 0; i < 16; i++) tick();
    total++; if (idle !== 1'b0)        begin bad++; $display("FAIL to_still_wait: got %b want 0", idle); end
    tick();
    total++; if (idle !== 1'b1)        begin bad++; $display("FAIL to_back_idle: got %b want 1", idle); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_err_set: got %b want 1", timeout_err); end
    total++; if (rx_level !== 3'd0)    begin bad++; $display("FAIL to_no_push: got %0d want 0", rx_level); end
`else
    for (int i = 0; i < 40; i++) tick();
    total++; if (idle !== 1'b0)        begin bad++; $display("FAIL hold_wait: got %b want 0", idle); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL hold_err: got %b want 0", timeout_err); end
    total++; if (rx_level !== 3'd0)    begin bad++; $display("FAIL hold_no_push: got %0d want 0", rx_level); end
    reset = 1'b1; tick(); reset = 1'b0; tick();
    total++; if (idle !== 1'b1)        begin bad++; $display("FAIL hold_reset_idle: got %b want 1", idle); end
`endif
    mute = 1'b0;
    push_byte(8'h78);
    n = 0;
    while (!rx_valid && n < 50) begin tick(); n++; end
    total++; if (rx_data !== 8'h87) begin bad++; $display("FAIL nodone_next: got %h want 87", rx_data); end
`ifdef SPI_TIMEOUT_EN
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_err_sticky: got %b want 1", timeout_err); end
`endif
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_full_both();
    test_reset_mid();
    test_no_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
